// File: rtl/paddsb_arbiter.sv
// Two-requester round-robin arbiter feeding a packed signed-saturating nibble adder,
// with a valid/ready result register. Define PADDSB_ARB_SAT_FLAGS_EN to build per-lane clamp flags.

// 4 x 4-bit signed lanes, each clamped to [-8, +7]; no carry between lanes.
module paddsb (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
`ifdef PADDSB_ARB_SAT_FLAGS_EN
    ,
    output logic [3:0]  sat
`endif
);

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 4;

    logic [LANE_W-1:0] na;
    logic [LANE_W-1:0] nb;
    logic [LANE_W:0]   raw;
    logic [LANES-1:0]  clamp;

    // raw is the 5-bit signed sum; bits 4 and 3 disagree exactly when the lane leaves [-8, +7]
    always_comb begin
        sum   = '0;
        clamp = '0;
        na    = '0;
        nb    = '0;
        raw   = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            na  = a[LANE_W*i +: LANE_W];
            nb  = b[LANE_W*i +: LANE_W];
            raw = {na[LANE_W-1], na} + {nb[LANE_W-1], nb};
            if (!raw[LANE_W] && raw[LANE_W-1]) begin
                sum[LANE_W*i +: LANE_W] = 4'h7;
                clamp[i]                = 1'b1;
            end else if (raw[LANE_W] && !raw[LANE_W-1]) begin
                sum[LANE_W*i +: LANE_W] = 4'h8;
                clamp[i]                = 1'b1;
            end else begin
                sum[LANE_W*i +: LANE_W] = raw[LANE_W-1:0];
            end
        end
    end

`ifdef PADDSB_ARB_SAT_FLAGS_EN
    assign sat = clamp;
`endif

endmodule

module paddsb_arbiter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [15:0]      req0_a,
    input  logic [15:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [15:0]      req1_a,
    input  logic [15:0]      req1_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic             out_id,
    output logic [3:0]       out_sat,
    output logic [CNT_W-1:0] op_cnt,
    output logic             busy
);

    localparam int unsigned DATA_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              prio_q;
    logic              can_accept;
    logic              win_id;
    logic              grant;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] lane_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Grant and next state; readies are gated by rst_n so they drop as soon as reset asserts
    always_comb begin
        state_d    = state_q;
        can_accept = 1'b0;
        win_id     = 1'b0;
        grant      = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        can_accept = (state_q == EMPTY) || out_ready;
        win_id     = (req0_valid && req1_valid) ? prio_q : req1_valid;
        grant      = rst_n && can_accept && (req0_valid || req1_valid);
        req0_ready = grant && !win_id;
        req1_ready = grant && win_id;

        case (state_q)
            EMPTY: if (grant) state_d = FULL;
            FULL:  if (out_ready && !grant) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    assign op_a = win_id ? req1_a : req0_a;
    assign op_b = win_id ? req1_b : req0_b;

`ifdef PADDSB_ARB_SAT_FLAGS_EN
    logic [3:0] lane_sat;

    paddsb u_paddsb (
        .a   (op_a),
        .b   (op_b),
        .sum (lane_sum),
        .sat (lane_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     out_sat <= 4'b0000;
        else if (grant) out_sat <= lane_sat;
    end
`else
    paddsb u_paddsb (
        .a   (op_a),
        .b   (op_b),
        .sum (lane_sum)
    );

    assign out_sat = 4'b0000;
`endif

    // Result register, round-robin pointer and consumed-result counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum <= '0;
            out_id  <= 1'b0;
            prio_q  <= 1'b0;
            op_cnt  <= '0;
        end else begin
            if (grant) begin
                out_sum <= lane_sum;
                out_id  <= win_id;
                prio_q  <= ~win_id;
            end
            if (out_valid && out_ready) op_cnt <= op_cnt + CNT_W'(1);
        end
    end

    assign out_valid = (state_q == FULL);
    assign busy      = out_valid;

endmodule

// File: tb/tb_paddsb_arbiter.sv
// Randomized and directed bench for paddsb_arbiter against a rule-level reference model.
module tb_paddsb_arbiter;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0, out_ready = 1'b0;
    logic [15:0]      req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             req0_ready, req1_ready, out_valid, out_id, busy;
    logic [15:0]      out_sum;
    logic [3:0]       out_sat;
    logic [CNT_W-1:0] op_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic             m_valid = 1'b0, m_id = 1'b0, m_prio = 1'b0;
    logic [15:0]      m_sum = '0;
    logic [3:0]       m_sat = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic             last_r0 = 1'b0, last_r1 = 1'b0;

    always #5 clk = ~clk;

    paddsb_arbiter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_id     (out_id),
        .out_sat    (out_sat),
        .op_cnt     (op_cnt),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Lane-wise saturating add using integer arithmetic
    task automatic ref_add(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] s, output logic [3:0] f);
        int x, y, r;
        s = '0;
        f = '0;
        for (int i = 0; i < 4; i++) begin
            x = (a >> (4 * i)) & 15;
            y = (b >> (4 * i)) & 15;
            if (x > 7) x -= 16;
            if (y > 7) y -= 16;
            r = x + y;
            if (r > 7)       begin r = 7;  f[i] = 1'b1; end
            else if (r < -8) begin r = -8; f[i] = 1'b1; end
            s = s | (16'(r & 15) << (4 * i));
        end
`ifndef PADDSB_ARB_SAT_FLAGS_EN
        f = '0;
`endif
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("busy",      32'(busy),      32'(m_valid));
        check("out_sum",   32'(out_sum),   32'(m_sum));
        check("out_id",    32'(out_id),    32'(m_id));
        check("out_sat",   32'(out_sat),   32'(m_sat));
        check("op_cnt",    32'(op_cnt),    32'(m_cnt));
    endtask

    // Called at a negedge with inputs already driven; advances one cycle and returns at the next negedge
    task automatic step();
        logic can_acc, any, win, r0, r1;
        logic [15:0] s;
        logic [3:0]  f;
        #1;
        can_acc = !m_valid || out_ready;
        any     = req0_valid || req1_valid;
        if (req0_valid && req1_valid) win = m_prio;
        else                          win = req1_valid;
        r0 = can_acc && any && (win == 1'b0);
        r1 = can_acc && any && (win == 1'b1);
        check("req0_ready", 32'(req0_ready), 32'(r0));
        check("req1_ready", 32'(req1_ready), 32'(r1));
        check_outputs();
        if (win) ref_add(req1_a, req1_b, s, f);
        else     ref_add(req0_a, req0_b, s, f);
        last_r0 = r0;
        last_r1 = r1;
        @(posedge clk);
        if (m_valid && out_ready) m_cnt = m_cnt + 1'b1;
        if (r0 || r1) begin
            m_valid = 1'b1;
            m_sum   = s;
            m_sat   = f;
            m_id    = win;
            m_prio  = !win;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_id = 1'b0; m_prio = 1'b0;
        m_sum = '0; m_sat = '0; m_cnt = '0;
        last_r0 = 1'b0; last_r1 = 1'b0;
    endtask

    // Assert reset at a negedge, check the asynchronous effect, release at the following negedge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_req0_ready", 32'(req0_ready), 32'(0));
        check("rst_req1_ready", 32'(req1_ready), 32'(0));
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                         input logic v1, input logic [15:0] a1, input logic [15:0] b1,
                         input logic ordy);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        out_ready  = ordy;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // single req0 operation
        drive(1, 16'h1234, 16'h4321, 0, 16'h0, 16'h0, 1);
        step();
        check("t1_valid", 32'(out_valid), 32'(1));
        check("t1_sum",   32'(out_sum),   32'h5555);
        check("t1_id",    32'(out_id),    32'(0));
        check("t1_sat",   32'(out_sat),   32'(0));
        drive(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        step();
        check("t1_cnt", 32'(op_cnt), 32'(1));

        // req1 saturating operations, back to back
        drive(0, 16'h0, 16'h0, 1, 16'hFFFF, 16'h0008, 1);
        step();
        check("t2a_sum", 32'(out_sum), 32'hFFF8);
        check("t2a_id",  32'(out_id),  32'(1));
`ifdef PADDSB_ARB_SAT_FLAGS_EN
        check("t2a_sat", 32'(out_sat), 32'h1);
`else
        check("t2a_sat", 32'(out_sat), 32'h0);
`endif
        drive(0, 16'h0, 16'h0, 1, 16'h7777, 16'h1111, 1);
        step();
        check("t2b_sum", 32'(out_sum), 32'h7777);
`ifdef PADDSB_ARB_SAT_FLAGS_EN
        check("t2b_sat", 32'(out_sat), 32'hF);
`else
        check("t2b_sat", 32'(out_sat), 32'h0);
`endif

        // both valid: grants alternate starting with req0
        drive(1, 16'hAAAA, 16'h5555, 1, 16'h0000, 16'h0000, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_id",  32'(out_id),  32'(i % 2));
            check("t3_sum", 32'(out_sum), (i % 2 == 0) ? 32'hFFFF : 32'h0000);
        end

        // backpressure while full
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b1;
        step();
        drive(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        step();

        // reset while holding an id=1 result
        drive(0, 16'h0, 16'h0, 1, 16'h0123, 16'h0456, 0);
        step();
        check("t5_id_before", 32'(out_id), 32'(1));
        drive(1, 16'h1111, 16'h2222, 1, 16'h3333, 16'h4444, 1);
        do_reset();
        step();
        check("t5_winner", 32'(out_id), 32'(0));
        check("t5_sum",    32'(out_sum), 32'h3333);

        // randomized traffic honouring the hold-while-not-ready rule
        for (int n = 0; n < 600; n++) begin
            if (!(req0_valid && !last_r0)) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_a     = 16'($urandom);
                req0_b     = 16'($urandom);
            end
            if (!(req1_valid && !last_r1)) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_a     = 16'($urandom);
                req1_b     = 16'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // counter wrap: 2^CNT_W + 1 consumed results from reset
        drive(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        do_reset();
        drive(1, 16'h0101, 16'h0202, 0, 16'h0, 16'h0, 1);
        for (int n = 0; n < (1 << CNT_W) + 2; n++) step();
        check("wrap_cnt", 32'(op_cnt), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
